// File: rtl/sdram_cmd_scheduler_if.sv
// SDRAM controller command/data bus seen by the command scheduler.
// master: the scheduler issuing commands; slave: the SDRAM controller.
interface sdram_cmd_scheduler_if;
    logic [1:0]  sys_cmd;            // 00 nop, 01 wr 256B, 10 rd 32B, 11 rd 256B
    logic [17:0] sys_addr;           // word address for sys_cmd
    logic [1:0]  sys_cmd_ack;        // code being accepted, 00 when none
    logic        sys_rd_data_valid;  // one read word on sys_dout
    logic        sys_wr_data_valid;  // one write word consumed
    logic [15:0] sys_dout;           // read data

    modport master (
        output sys_cmd, sys_addr,
        input  sys_cmd_ack, sys_rd_data_valid, sys_wr_data_valid, sys_dout
    );

    modport slave (
        input  sys_cmd, sys_addr,
        output sys_cmd_ack, sys_rd_data_valid, sys_wr_data_valid, sys_dout
    );
endinterface

// File: rtl/sdram_cmd_scheduler.sv
// Arbitrates video-FIFO refills and cache write-back/fill traffic onto a
// single SDRAM command port. One transaction in flight at a time:
// IDLE (arbitrate) -> ISSUE (hold command until acked) -> XFER (count words).
module sdram_cmd_scheduler #(
    parameter logic [14:0] VID_BASE    = 15'h6FF8,
    parameter int          VID_LAST    = 3071,
    parameter int          MAX_VID_RUN = 4
) (
    input  logic                         clk,
    input  logic                         rst,          // async, active-low
    input  logic                         vid_low,
    input  logic                         cache_wr_req,
    input  logic                         cache_rd_req,
    input  logic [11:0]                  cache_waddr,
    input  logic [11:0]                  cache_raddr,
    sdram_cmd_scheduler_if.master        sdram,
    output logic                         cache_fill_we,
    output logic                         cache_wb_re,
    output logic                         vid_we,
    output logic [31:0]                  vid_data,
    output logic                         busy
);

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_VRD = 2'b10;
    localparam logic [1:0] CMD_CRD = 2'b11;
    localparam int         RUN_W   = $clog2(MAX_VID_RUN + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;

    state_t            state, state_nxt;
    logic [1:0]        cmd_q;      // code in flight; doubles as the data route
    logic [11:0]       vidadr;     // next video line to fetch
    logic [RUN_W-1:0]  vid_run;    // back-to-back video grants
    logic [6:0]        word_cnt;
    logic              phase;      // 1 = next video word completes a pair
    logic [15:0]       half_q;     // first half of the current video pair

    logic              cache_first, grant_any, ack_ok, strobe, last_word, done;
    logic [1:0]        grant_code;
    logic [17:0]       grant_addr;
    logic [14:0]       vid_line;

    // Video lines are stored bottom-up in the framebuffer, hence the inverted
    // upper index bits; the sum wraps within the 15-bit 32-byte-unit space.
    assign vid_line    = VID_BASE + {3'b000, ~vidadr[11:2], vidadr[1:0]};

    // A starved cache request beats video once the video run has saturated.
    assign cache_first = (cache_wr_req | cache_rd_req) && (vid_run == RUN_W'(MAX_VID_RUN));

    // Pick the winning request and its command/address while idle.
    always_comb begin
        grant_code = CMD_NOP;
        grant_addr = '0;
        if (vid_low && !cache_first) begin
            grant_code = CMD_VRD;
            grant_addr = {vid_line, 3'b000};
        end else if (cache_wr_req) begin
            grant_code = CMD_WR;
            grant_addr = {cache_waddr, 6'b0};
        end else if (cache_rd_req) begin
            grant_code = CMD_CRD;
            grant_addr = {cache_raddr, 6'b0};
        end
    end

    assign grant_any = (state == IDLE) && (grant_code != CMD_NOP);
    // Only the ack matching the issued code counts; others are ignored.
    assign ack_ok    = (state == ISSUE) && (sdram.sys_cmd_ack == cmd_q);
    // Only strobes of the kind the transaction expects advance the count.
    assign strobe    = (state == XFER) &&
                       ((cmd_q == CMD_WR) ? sdram.sys_wr_data_valid : sdram.sys_rd_data_valid);
    assign last_word = (word_cnt == ((cmd_q == CMD_VRD) ? 7'd15 : 7'd127));
    assign done      = strobe && last_word;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = ISSUE;
            ISSUE:   if (ack_ok)    state_nxt = XFER;
            XFER:    if (done)      state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Command, address and transfer bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sdram.sys_cmd  <= CMD_NOP;
            sdram.sys_addr <= '0;
            cmd_q          <= CMD_NOP;
            vidadr         <= '0;
            vid_run        <= '0;
            word_cnt       <= '0;
            phase          <= 1'b0;
            half_q         <= '0;
        end else begin
            if (grant_any) begin
                sdram.sys_cmd  <= grant_code;
                sdram.sys_addr <= grant_addr;
                cmd_q          <= grant_code;
                word_cnt       <= '0;
                phase          <= 1'b0;
                if (grant_code == CMD_VRD) begin
                    if (vid_run != RUN_W'(MAX_VID_RUN)) vid_run <= vid_run + 1'b1;
                end else begin
                    vid_run <= '0;
                end
            end
            if (ack_ok) begin
                sdram.sys_cmd <= CMD_NOP;
                if (cmd_q == CMD_VRD)
                    vidadr <= (vidadr == 12'(VID_LAST)) ? 12'd0 : vidadr + 12'd1;
            end
            if (strobe) begin
                word_cnt <= word_cnt + 7'd1;
                if (cmd_q == CMD_VRD) begin
                    phase <= ~phase;
                    if (!phase) half_q <= sdram.sys_dout;
                end
            end
        end
    end

    // Outputs: data-path enables follow the strobes combinationally in XFER.
    always_comb begin
        busy          = (state != IDLE);
        cache_fill_we = (state == XFER) && (cmd_q == CMD_CRD) && sdram.sys_rd_data_valid;
        cache_wb_re   = (state == XFER) && (cmd_q == CMD_WR)  && sdram.sys_wr_data_valid;
        vid_we        = (state == XFER) && (cmd_q == CMD_VRD) && sdram.sys_rd_data_valid && phase;
        vid_data      = {sdram.sys_dout, half_q};
    end

endmodule
